// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar scheduler: port counts, arbiter state
// encoding and the round-robin winner search.
package crossbar_pkg;

  localparam int N_PORTS = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // First requester found scanning ptr, ptr+1, ... with natural mod-4 wrap.
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [N_PORTS-1:0] req,
    input logic [SEL_W-1:0]   ptr
  );
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] win;
    logic             found;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/crossbar_out_arb.sv
// One output controller: round-robin grant from IDLE, then hold the owner
// until its last beat transfers.
module crossbar_out_arb
  import crossbar_pkg::*;
#(
  parameter logic [SEL_W-1:0] OUT_IDX = 2'd0,
  parameter bit               LOCK_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_PORTS-1:0]       in_vld,
  input  logic [N_PORTS*SEL_W-1:0] in_dst,
  input  logic [N_PORTS-1:0]       in_last,
  input  logic                     out_rdy,
  output logic                     out_vld,
  output logic [N_PORTS-1:0]       in_rdy,
  output logic [SEL_W-1:0]         sel
);

  arb_state_e         state, state_nxt;
  logic [SEL_W-1:0]   owner, owner_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [N_PORTS-1:0] cand;
  logic               xfer;
  logic               done;

  // Inputs currently requesting this output.
  always_comb begin
    cand = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand[i] = in_vld[i] && (in_dst[i*SEL_W +: SEL_W] == OUT_IDX);
    end
  end

  assign out_vld = (state == ST_LOCKED) && cand[owner];
  assign xfer    = out_vld && out_rdy;
  assign done    = xfer && (!LOCK_EN || in_last[owner]);
  // The select always equals the registered owner, so it holds while IDLE.
  assign sel     = owner;

  // Ready goes only to the owner, and only on a transfer.
  always_comb begin
    if (xfer) begin
      in_rdy = {{(N_PORTS-1){1'b0}}, 1'b1} << owner;
    end else begin
      in_rdy = '0;
    end
  end

  // Next-state logic: arbitration happens only in IDLE, release on last beat.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    case (state)
      ST_IDLE: begin
        if (|cand) begin
          state_nxt = ST_LOCKED;
          owner_nxt = rr_pick(cand, ptr);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (done) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = owner + SEL_W'(1);
        end else begin
          state_nxt = ST_LOCKED;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, owner and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: rtl/crossbar_sched.sv
// 4x4 crossbar scheduler: four independent output arbiters whose per-input
// ready vectors are merged into one IN_RDY.
module crossbar_sched
  import crossbar_pkg::*;
#(
  parameter bit LOCK_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] IN_VLD,
  input  logic [7:0] IN_DST,
  input  logic [3:0] IN_LAST,
  output logic [3:0] IN_RDY,
  input  logic [3:0] OUT_RDY,
  output logic [3:0] OUT_VLD,
  output logic [1:0] SEL0,
  output logic [1:0] SEL1,
  output logic [1:0] SEL2,
  output logic [1:0] SEL3
);

  logic [N_PORTS-1:0] rdy_per_out [N_PORTS];
  logic [SEL_W-1:0]   sel_per_out [N_PORTS];

  for (genvar o = 0; o < N_PORTS; o++) begin : g_out
    crossbar_out_arb #(
      .OUT_IDX (SEL_W'(o)),
      .LOCK_EN (LOCK_EN)
    ) u_arb (
      .clk     (CLK),
      .rst_n   (RST_N),
      .in_vld  (IN_VLD),
      .in_dst  (IN_DST),
      .in_last (IN_LAST),
      .out_rdy (OUT_RDY[o]),
      .out_vld (OUT_VLD[o]),
      .in_rdy  (rdy_per_out[o]),
      .sel     (sel_per_out[o])
    );
  end

  // An input targets one output at a time, so at most one term is set per bit.
  always_comb begin
    IN_RDY = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      IN_RDY = IN_RDY | rdy_per_out[o];
    end
  end

  assign SEL0 = sel_per_out[0];
  assign SEL1 = sel_per_out[1];
  assign SEL2 = sel_per_out[2];
  assign SEL3 = sel_per_out[3];

endmodule

// File: tb/tb_crossbar_sched.sv
// Self-checking bench for crossbar_sched: directed scenarios plus random
// packet traffic compared against a per-output lock/round-robin model.
module tb_crossbar_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in_vld, in_last, out_rdy;
  logic [7:0] in_dst;
  logic [3:0] in_rdy, out_vld, in_rdy_b, out_vld_b;
  logic [1:0] sel0, sel1, sel2, sel3;
  logic [1:0] selb0, selb1, selb2, selb3;

  always #5 clk = ~clk;

  crossbar_sched #(.LOCK_EN(1'b1)) dut (
    .CLK(clk), .RST_N(rst_n), .IN_VLD(in_vld), .IN_DST(in_dst), .IN_LAST(in_last),
    .IN_RDY(in_rdy), .OUT_RDY(out_rdy), .OUT_VLD(out_vld),
    .SEL0(sel0), .SEL1(sel1), .SEL2(sel2), .SEL3(sel3)
  );

  crossbar_sched #(.LOCK_EN(1'b0)) dut_nolock (
    .CLK(clk), .RST_N(rst_n), .IN_VLD(in_vld), .IN_DST(in_dst), .IN_LAST(in_last),
    .IN_RDY(in_rdy_b), .OUT_RDY(out_rdy), .OUT_VLD(out_vld_b),
    .SEL0(selb0), .SEL1(selb1), .SEL2(selb2), .SEL3(selb3)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per output a lock flag, the owning input and the scan start.
  bit         m_locked [4];
  int         m_owner  [4];
  int         m_ptr    [4];
  logic [3:0] exp_vld, exp_rdy;
  int         exp_sel  [4];

  // Traffic engine: beats left in the current packet, its destination, stall.
  int left [4];
  int pdst [4];
  bit hold [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_proto
    assert property (@(posedge clk) disable iff (!rst_n)
      (in_vld[gi] && !in_rdy[gi]) |=> (!in_vld[gi] ||
        (in_dst[2*gi +: 2] == $past(in_dst[2*gi +: 2]) && in_last[gi] == $past(in_last[gi]))))
      else $error("input %0d protocol violation", gi);
  end

  function automatic int dst_of(int i);
    return int'(in_dst[2*i +: 2]);
  endfunction

  function automatic void model_comb();
    exp_vld = '0;
    exp_rdy = '0;
    for (int o = 0; o < 4; o++) begin
      int w = m_owner[o];
      exp_sel[o] = w;
      if (m_locked[o] && in_vld[w] && dst_of(w) == o) begin
        exp_vld[o] = 1'b1;
        if (out_rdy[o]) exp_rdy[w] = 1'b1;
      end
    end
  endfunction

  function automatic void model_seq();
    for (int o = 0; o < 4; o++) begin
      if (m_locked[o]) begin
        if (exp_vld[o] && out_rdy[o] && in_last[m_owner[o]]) begin
          m_locked[o] = 1'b0;
          m_ptr[o]    = (m_owner[o] + 1) % 4;
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          int i = (m_ptr[o] + k) % 4;
          if (!m_locked[o] && in_vld[i] && dst_of(i) == o) begin
            m_locked[o] = 1'b1;
            m_owner[o]  = i;
          end
        end
      end
    end
  endfunction

  function automatic logic [15:0] dut_vec();
    return {out_vld, in_rdy, sel3, sel2, sel1, sel0};
  endfunction

  function automatic logic [15:0] exp_vec();
    return {exp_vld, exp_rdy, 2'(exp_sel[3]), 2'(exp_sel[2]), 2'(exp_sel[1]), 2'(exp_sel[0])};
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      in_vld[i]         = (left[i] > 0) && !hold[i];
      in_last[i]        = (left[i] == 1);
      in_dst[2*i +: 2]  = 2'(pdst[i]);
    end
  endtask

  task automatic to_sample();
    drive();
    @(negedge clk);
    model_comb();
  endtask

  task automatic advance();
    @(posedge clk);
    model_seq();
    for (int i = 0; i < 4; i++) if (exp_rdy[i]) left[i]--;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      left[i] = 0; pdst[i] = 0; hold[i] = 1'b0;
      m_locked[i] = 1'b0; m_owner[i] = 0; m_ptr[i] = 0;
    end
    out_rdy = 4'hF;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_vld = 4'h0; in_last = 4'h0; in_dst = 8'h00; out_rdy = 4'hF;
    #2;
    checks++;
    if (dut_vec() !== 16'h0000) begin
      errors++; $display("FAIL reset_assert: got %h expected %h", dut_vec(), 16'h0000);
    end
    do_reset();
    to_sample();
    checks++;
    if (dut_vec() !== exp_vec() || {out_vld_b, in_rdy_b} !== 8'h00) begin
      errors++; $display("FAIL reset_release: got %h expected %h", dut_vec(), exp_vec());
    end
    advance();
  endtask

  task automatic test_single_packet();
    int beats = 0;
    do_reset();
    left[0] = 3; pdst[0] = 2;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) begin
        left[0] = 1; left[1] = 1; left[2] = 1; pdst[1] = 2; pdst[2] = 2;
      end
      to_sample();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL single_pkt cyc %0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      if (k >= 1 && k <= 3 && in_rdy[0]) beats++;
      if (k == 1) begin
        checks++;
        if (sel2 !== 2'd0 || out_vld[2] !== 1'b1 || in_rdy !== 4'b0001) begin
          errors++; $display("FAIL single_pkt_lock: sel2 %0d vld %b rdy %b expected 0 1 0001", sel2, out_vld[2], in_rdy);
        end
      end
      if (k == 5) begin
        checks++;
        if (sel2 !== 2'd1 || in_rdy !== 4'b0010) begin
          errors++; $display("FAIL single_pkt_ptr: sel2 %0d rdy %b expected 1 0010", sel2, in_rdy);
        end
      end
      advance();
    end
    checks++;
    if (beats != 3) begin
      errors++; $display("FAIL single_pkt_beats: got %0d expected 3", beats);
    end
  endtask

  task automatic test_rr_fairness();
    do_reset();
    for (int i = 0; i < 4; i++) begin left[i] = 1; pdst[i] = 1; end
    for (int k = 0; k < 10; k++) begin
      logic [3:0] want;
      to_sample();
      want = (k % 2 == 1) ? (4'b0001 << (((k - 1) / 2) % 4)) : 4'b0000;
      checks++;
      if (dut_vec() !== exp_vec() || in_rdy !== want) begin
        errors++; $display("FAIL rr_order cyc %0d: rdy %b expected %b (vec %h exp %h)", k, in_rdy, want, dut_vec(), exp_vec());
      end
      if (k % 2 == 1) begin
        checks++;
        if (sel1 !== 2'(((k - 1) / 2) % 4)) begin
          errors++; $display("FAIL rr_sel cyc %0d: got %0d expected %0d", k, sel1, ((k - 1) / 2) % 4);
        end
      end
      advance();
      for (int i = 0; i < 4; i++) if (left[i] == 0) left[i] = 1;
    end
  endtask

  task automatic test_stall();
    int got2 = 0;
    do_reset();
    left[1] = 4; pdst[1] = 3;
    left[2] = 1; pdst[2] = 3;
    for (int k = 0; k < 12; k++) begin
      out_rdy = (k >= 2 && k <= 5) ? 4'b0111 : 4'b1111;
      hold[1] = (k == 3 || k == 4);
      to_sample();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL stall cyc %0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      if (k >= 1 && k <= 8) begin
        checks++;
        if (sel3 !== 2'd1 || in_rdy[2] !== 1'b0 || (k >= 2 && k <= 5 && in_rdy[1] !== 1'b0)) begin
          errors++; $display("FAIL stall_lock cyc %0d: sel3 %0d rdy %b expected sel3 1, no transfer", k, sel3, in_rdy);
        end
      end
      if (in_rdy[2]) got2++;
      advance();
    end
    checks++;
    if (got2 != 1) begin
      errors++; $display("FAIL stall_waiter: input 2 beats %0d expected 1", got2);
    end
  endtask

  task automatic test_permutation();
    do_reset();
    for (int i = 0; i < 4; i++) begin left[i] = 3; pdst[i] = 3 - i; end
    for (int k = 0; k < 5; k++) begin
      to_sample();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL perm cyc %0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      if (k >= 1 && k <= 3) begin
        checks++;
        if ({sel3, sel2, sel1, sel0} !== 8'b00_01_10_11 || in_rdy !== 4'hF || out_vld !== 4'hF) begin
          errors++; $display("FAIL perm_parallel cyc %0d: sel %h rdy %b vld %b expected 1b 1111 1111", k, {sel3, sel2, sel1, sel0}, in_rdy, out_vld);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    left[1] = 5; pdst[1] = 0;
    for (int k = 0; k < 3; k++) begin
      to_sample();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL midrst_pre cyc %0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      advance();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 16'h0000) begin
      errors++; $display("FAIL midrst_async: got %h expected %h", dut_vec(), 16'h0000);
    end
    do_reset();
    left[3] = 2; pdst[3] = 0;
    for (int k = 0; k < 4; k++) begin
      to_sample();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL midrst_post cyc %0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      if (k == 1) begin
        checks++;
        if (sel0 !== 2'd3 || in_rdy !== 4'b1000) begin
          errors++; $display("FAIL midrst_grant: sel0 %0d rdy %b expected 3 1000", sel0, in_rdy);
        end
      end
      advance();
    end
  endtask

  task automatic test_lock_en0();
    do_reset();
    left[0] = 1000; pdst[0] = 0;
    left[2] = 1000; pdst[2] = 0;
    for (int k = 0; k < 8; k++) begin
      int         idx;
      logic [7:0] want;
      to_sample();
      idx  = (k % 4 == 1) ? 0 : 2;
      want = (k % 2 == 1) ? {4'b0001, 4'b0001 << idx} : 8'h00;
      checks++;
      if ({out_vld_b, in_rdy_b} !== want || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL nolock cyc %0d: vld/rdy %h expected %h (locked vec %h exp %h)", k, {out_vld_b, in_rdy_b}, want, dut_vec(), exp_vec());
      end
      if (k % 2 == 1) begin
        checks++;
        if (selb0 !== 2'(idx) || {selb3, selb2, selb1} !== 6'd0) begin
          errors++; $display("FAIL nolock_sel cyc %0d: sel0 %0d expected %0d", k, selb0, idx);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (left[i] == 0 && $urandom_range(0, 3) != 0) begin
          left[i] = $urandom_range(1, 4);
          pdst[i] = $urandom_range(0, 3);
        end
        hold[i] = ($urandom_range(0, 3) == 0);
      end
      out_rdy = 4'($urandom);
      to_sample();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %h expected %h", k, dut_vec(), exp_vec());
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_rr_fairness();
    test_stall();
    test_permutation();
    test_reset_midpacket();
    test_lock_en0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
